// File: rtl/login_check_ctrl.sv
// Keypad login checker: collects BCD digits, compares against PASSWORD, holds PASS/FAIL, counts retries.
// Retry lockout (LOCK state, Locked, code 11) is built only when LOGIN_LOCKOUT_EN is defined.
module login_check_ctrl #(
    parameter int                      NUM_DIGITS  = 4,
    parameter logic [4*NUM_DIGITS-1:0] PASSWORD    = 16'h1234,
    parameter int                      HOLD_CYCLES = 50_000_000,
    parameter int                      MAX_FAILS   = 3,
    parameter int                      LOCK_CYCLES = 500_000_000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] DigitIn,
    input  logic       DigitValid,
    input  logic       Clear,
    output logic [1:0] WarningFlag,
    output logic [2:0] DigitCount,
    output logic       Locked
);

`ifdef LOGIN_LOCKOUT_EN
    localparam int TMAX = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
    typedef enum logic [2:0] {S_ENTRY, S_CHECK, S_PASS, S_FAIL, S_LOCK} state_t;
`else
    localparam int TMAX = HOLD_CYCLES;
    typedef enum logic [2:0] {S_ENTRY, S_CHECK, S_PASS, S_FAIL} state_t;
`endif
    localparam int            TW        = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [3:0]    ND        = 4'(NUM_DIGITS);
    localparam logic [3:0]    MF        = 4'(MAX_FAILS);

    state_t                  state;
    logic [TW-1:0]           timer;
    logic [3:0]              cnt;
    logic [3:0]              fail_cnt;
    logic [1:0]              flag;
    logic [4*NUM_DIGITS-1:0] entry_buf;
    logic [4*NUM_DIGITS-1:0] next_buf;

    generate
        if (NUM_DIGITS == 1) begin : g_one
            assign next_buf = DigitIn;
        end else begin : g_many
            assign next_buf = {entry_buf[4*NUM_DIGITS-5:0], DigitIn};
        end
    endgenerate

`ifdef LOGIN_LOCKOUT_EN
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
    logic locked_q;
    assign Locked = locked_q;
`else
    assign Locked = 1'b0;
`endif

    assign WarningFlag = flag;
    assign DigitCount  = cnt[2:0];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= S_ENTRY;
            timer     <= '0;
            cnt       <= '0;
            fail_cnt  <= '0;
            flag      <= 2'b00;
            entry_buf <= '0;
`ifdef LOGIN_LOCKOUT_EN
            locked_q  <= 1'b0;
`endif
        end else begin
            case (state)
                S_ENTRY: begin
                    // A full entry spends one cycle here before CHECK; strobes in that cycle are dropped.
                    if (cnt == ND) begin
                        state <= S_CHECK;
                    end else if (Clear) begin
                        entry_buf <= '0;
                        cnt       <= '0;
                    end else if (DigitValid && (DigitIn <= 4'd9)) begin
                        entry_buf <= next_buf;
                        cnt       <= cnt + 4'd1;
                    end
                end
                S_CHECK: begin
                    timer <= HOLD_LOAD;
                    if (entry_buf == PASSWORD) begin
                        state    <= S_PASS;
                        flag     <= 2'b10;
                        fail_cnt <= '0;
                    end else begin
                        state <= S_FAIL;
                        flag  <= 2'b01;
                        if (fail_cnt != MF) fail_cnt <= fail_cnt + 4'd1;
                    end
                end
                S_PASS: begin
                    if (timer == '0) begin
                        state     <= S_ENTRY;
                        flag      <= 2'b00;
                        cnt       <= '0;
                        entry_buf <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_FAIL: begin
                    if (timer == '0) begin
`ifdef LOGIN_LOCKOUT_EN
                        if (fail_cnt == MF) begin
                            state    <= S_LOCK;
                            flag     <= 2'b11;
                            locked_q <= 1'b1;
                            timer    <= LOCK_LOAD;
                        end else begin
                            state     <= S_ENTRY;
                            flag      <= 2'b00;
                            cnt       <= '0;
                            entry_buf <= '0;
                        end
`else
                        state     <= S_ENTRY;
                        flag      <= 2'b00;
                        cnt       <= '0;
                        entry_buf <= '0;
`endif
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
`ifdef LOGIN_LOCKOUT_EN
                S_LOCK: begin
                    if (timer == '0) begin
                        state     <= S_ENTRY;
                        flag      <= 2'b00;
                        locked_q  <= 1'b0;
                        fail_cnt  <= '0;
                        cnt       <= '0;
                        entry_buf <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
`endif
                default: state <= S_ENTRY;
            endcase
        end
    end

endmodule

// File: tb/tb_login_check_ctrl.sv
// Bench for login_check_ctrl: directed and random entries against an entry-level outcome model.
module tb_login_check_ctrl;
    localparam int ND    = 4;
    localparam int HOLD  = 8;
    localparam int LOCKC = 20;
    localparam int MAXF  = 3;
`ifdef LOGIN_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [3:0] DigitIn = 4'd0;
    logic       DigitValid = 1'b0;
    logic       Clear = 1'b0;
    logic [1:0] WarningFlag;
    logic [2:0] DigitCount;
    logic       Locked;

    int errors = 0;
    int checks = 0;
    int fails  = 0;
    int feed[$];
    int pwd[4] = '{1, 2, 3, 4};

    login_check_ctrl #(
        .NUM_DIGITS (ND),
        .PASSWORD   (16'h1234),
        .HOLD_CYCLES(HOLD),
        .MAX_FAILS  (MAXF),
        .LOCK_CYCLES(LOCKC)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .DigitIn    (DigitIn),
        .DigitValid (DigitValid),
        .Clear      (Clear),
        .WarningFlag(WarningFlag),
        .DigitCount (DigitCount),
        .Locked     (Locked)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic strobe(input int d);
        DigitIn    = 4'(d);
        DigitValid = 1'b1;
        step();
        DigitValid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_flag"},   8'(WarningFlag), 8'd0);
        chk({tag, "_count"},  8'(DigitCount),  8'd0);
        chk({tag, "_locked"}, 8'(Locked),      8'd0);
    endtask

    task automatic async_reset(input string tag);
        DigitValid = 1'b0;
        Clear      = 1'b0;
        Rst        = 1'b1;
        #1;
        chk_reset_vals(tag);
        step();
        step();
        Rst   = 1'b0;
        fails = 0;
        step();
        chk_reset_vals({tag, "_after"});
    endtask

    task automatic make_entry(input bit correct);
        feed.delete();
        for (int i = 0; i < ND; i++) begin
            if ($urandom_range(0, 4) == 0) feed.push_back(int'($urandom_range(10, 15)));
            feed.push_back(correct ? pwd[i] : int'($urandom_range(0, 9)));
        end
    endtask

    // Feed the queued keypresses, then follow the result and any lockout; abort>=0 resets mid-result.
    task automatic run_entry(input bit gaps, input int abort);
        int  acc;
        int  got[$];
        bit  ok;
        bit  lock;
        logic [1:0] want;
        acc = 0;
        foreach (feed[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) step();
            strobe(feed[i]);
            if (feed[i] <= 9) begin
                acc++;
                got.push_back(feed[i]);
            end
            chk("entry_count", 8'(DigitCount), 8'(acc));
        end
        ok = 1'b1;
        for (int i = 0; i < ND; i++) if (got[i] != pwd[i]) ok = 1'b0;
        if (ok) fails = 0;
        else if (fails < MAXF) fails++;
        lock = LOCK_EN && !ok && (fails == MAXF);
        want = ok ? 2'b10 : 2'b01;

        chk("latency_flag0", 8'(WarningFlag), 8'd0);
        DigitValid = 1'b1;
        DigitIn    = 4'd7;
        step();
        DigitValid = 1'b0;
        chk("latency_flag1", 8'(WarningFlag), 8'd0);
        step();
        for (int k = 0; k < HOLD; k++) begin
            if (abort >= 0 && !LOCK_EN && k == abort) begin
                async_reset("rst_mid_result");
                return;
            end
            chk("hold_flag", 8'(WarningFlag), 8'(want));
            chk("hold_locked", 8'(Locked), 8'd0);
            DigitValid = (k == HOLD - 1) ? 1'b1 : 1'($urandom_range(0, 1));
            Clear      = 1'($urandom_range(0, 1));
            DigitIn    = 4'($urandom_range(0, 9));
            step();
        end
        DigitValid = 1'b0;
        Clear      = 1'b0;
        if (lock) begin
            for (int k = 0; k < LOCKC; k++) begin
                if (abort >= 0 && k == abort) begin
                    async_reset("rst_mid_lock");
                    return;
                end
                chk("lock_flag", 8'(WarningFlag), 8'd3);
                chk("lock_locked", 8'(Locked), 8'd1);
                DigitValid = (k == LOCKC - 1) ? 1'b1 : 1'($urandom_range(0, 1));
                Clear      = 1'($urandom_range(0, 1));
                DigitIn    = 4'($urandom_range(0, 9));
                step();
            end
            DigitValid = 1'b0;
            Clear      = 1'b0;
            fails      = 0;
        end
        chk("exit_flag", 8'(WarningFlag), 8'd0);
        chk("exit_count", 8'(DigitCount), 8'd0);
        chk("exit_locked", 8'(Locked), 8'd0);
    endtask

    task automatic fixed_entry(input int a, input int b, input int c, input int d);
        feed.delete();
        feed.push_back(a);
        feed.push_back(b);
        feed.push_back(c);
        feed.push_back(d);
        run_entry(1'b0, -1);
    endtask

    initial begin
        #2;
        chk_reset_vals("reset");
        #10;
        Rst = 1'b0;
        step();
        chk_reset_vals("post_reset");

        fixed_entry(1, 2, 3, 4);
        fixed_entry(1, 2, 3, 5);
        fixed_entry(9, 9, 9, 9);
        fixed_entry(0, 0, 0, 0);
        fixed_entry(1, 2, 3, 4);

        strobe(1);
        strobe(2);
        chk("clear_pre_count", 8'(DigitCount), 8'd2);
        Clear      = 1'b1;
        DigitValid = 1'b1;
        DigitIn    = 4'd9;
        step();
        Clear      = 1'b0;
        DigitValid = 1'b0;
        chk("clear_count", 8'(DigitCount), 8'd0);
        feed.delete();
        feed.push_back(1);
        feed.push_back(2);
        feed.push_back(12);
        feed.push_back(3);
        feed.push_back(4);
        run_entry(1'b0, -1);

        fixed_entry(5, 5, 5, 5);
        fixed_entry(4, 3, 2, 1);
        fixed_entry(1, 2, 3, 4);
        fixed_entry(5, 5, 5, 5);
        fixed_entry(4, 3, 2, 1);
        fixed_entry(1, 2, 3, 4);

        strobe(1);
        strobe(2);
        strobe(3);
        chk("mid_entry_count", 8'(DigitCount), 8'd3);
        async_reset("rst_mid_entry");

        fixed_entry(6, 6, 6, 6);
        fixed_entry(6, 6, 6, 7);
        make_entry(1'b0);
        feed[0] = 8;
        run_entry(1'b1, 5);

        for (int n = 0; n < 25; n++) begin
            make_entry(1'($urandom_range(0, 1)));
            run_entry(1'b1, -1);
        end
        fixed_entry(1, 2, 3, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
